ethernet_sys_pio_poller: RTL

- Avalon-MM master that sequences periodic reads of the 8-bit input PIO slave (data register at word address 0, registered readdata).
- Debounces the sampled byte and publishes a stable value.
- Emits change events on a valid/ready interface, so downstream logic (IRQ/status, TCP status reporter) needs no CPU polling.
- Sits between the system interconnect master port and event consumers in ethernet_sys.

---
 rtl/ethernet_sys_pio_poller.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/ethernet_sys_pio_poller.sv
// ---------------------------------------------------------------------------
// ethernet_sys_pio_poller
//
// Avalon-MM read master that periodically samples the 8-bit input PIO (data
// register at word address 0), debounces the sampled byte and publishes the
// accepted value. Each accepted change is offered to downstream consumers as
// an event on a valid/ready interface, so no CPU polling of the PIO is needed.
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   enable              level; polling runs while high
//   clr_err             one-cycle pulse clearing the sticky error flags
//   m_address/m_read    Avalon read request (address is always 0)
//   m_waitrequest       Avalon waitrequest
//   m_readdata          Avalon read data, only [7:0] used
//   m_readdatavalid     Avalon read data valid
//   stable_value        last accepted debounced byte
//   ev_valid/ev_ready   change-event handshake
//   ev_data             new stable value carried by the event
//   ev_changed          bits changed since the last consumed event
//   err_timeout         sticky: a read got no data within TIMEOUT cycles
//   err_overflow        sticky: an unconsumed event was overwritten
//   busy                high while a poll transaction is in flight
// ---------------------------------------------------------------------------
module ethernet_sys_pio_poller #(
    parameter int POLL_INTERVAL  = 16,
    parameter int STABLE_SAMPLES = 3,
    parameter int TIMEOUT        = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        clr_err,
    output logic [1:0]  m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    input  logic        m_readdatavalid,
    output logic [7:0]  stable_value,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [7:0]  ev_data,
    output logic [7:0]  ev_changed,
    output logic        err_timeout,
    output logic        err_overflow,
    output logic        busy
);

    localparam int IW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int CW = $clog2(STABLE_SAMPLES + 1);

    localparam logic [IW-1:0] INT_RELOAD = IW'(POLL_INTERVAL - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ACCEPT = CW'(STABLE_SAMPLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_DATA,
        S_EVAL
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] int_cnt_q, int_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    sample_q, sample_d;
    logic [7:0]    stable_q, stable_d;
    logic [7:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ev_valid_q, ev_valid_d;
    logic [7:0]    ev_data_q, ev_data_d;
    logic [7:0]    ev_changed_q, ev_changed_d;
    logic          err_to_q, err_to_d;
    logic          err_ovf_q, err_ovf_d;

    logic          to_set;
    logic          ovf_set;
    logic          new_event;
    logic [7:0]    ev_mask;

    // Upper read-data bits carry nothing for an 8-bit PIO.
    logic unused_readdata_hi;
    assign unused_readdata_hi = ^m_readdata[31:8];

    always_comb begin
        state_d      = state_q;
        int_cnt_d    = int_cnt_q;
        to_cnt_d     = to_cnt_q;
        sample_d     = sample_q;
        stable_d     = stable_q;
        cand_d       = cand_q;
        cnt_d        = cnt_q;
        ev_valid_d   = ev_valid_q;
        ev_data_d    = ev_data_q;
        ev_changed_d = ev_changed_q;
        to_set       = 1'b0;
        ovf_set      = 1'b0;
        new_event    = 1'b0;
        ev_mask      = stable_q ^ sample_q;

        case (state_q)
            S_IDLE: begin
                // Counter only advances while enabled; it holds otherwise.
                if (enable) begin
                    if (int_cnt_q == '0) begin
                        state_d   = S_REQ;
                        int_cnt_d = INT_RELOAD;
                    end else begin
                        int_cnt_d = int_cnt_q - 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (!m_waitrequest) begin
                    state_d  = S_WAIT_DATA;
                    to_cnt_d = '0;
                end
            end
            S_WAIT_DATA: begin
                if (m_readdatavalid) begin
                    sample_d = m_readdata[7:0];
                    state_d  = S_EVAL;
                end else if (to_cnt_q == TO_LAST) begin
                    // TIMEOUT consecutive cycles without data: abandon.
                    to_set  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_EVAL: begin
                state_d = S_IDLE;
                if (sample_q == stable_q) begin
                    cnt_d = '0;
                end else if (sample_q == cand_q && cnt_q != '0) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cand_d = sample_q;
                    cnt_d  = CW'(1);
                end
                if (sample_q != stable_q && cnt_d == CNT_ACCEPT) begin
                    stable_d  = sample_q;
                    cnt_d     = '0;
                    new_event = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new event either starts fresh (slot free or being consumed this
        // cycle) or overwrites a pending one, accumulating the change mask.
        if (new_event) begin
            ev_data_d = sample_q;
            if (!ev_valid_q || ev_ready) begin
                ev_valid_d   = 1'b1;
                ev_changed_d = ev_mask;
            end else begin
                ev_changed_d = ev_changed_q | ev_mask;
                ovf_set      = 1'b1;
            end
        end else if (ev_valid_q && ev_ready) begin
            ev_valid_d = 1'b0;
        end

        // Setting wins over a simultaneous clear.
        err_to_d  = (err_to_q  & ~clr_err) | to_set;
        err_ovf_d = (err_ovf_q & ~clr_err) | ovf_set;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            int_cnt_q    <= INT_RELOAD;
            to_cnt_q     <= '0;
            sample_q     <= '0;
            stable_q     <= '0;
            cand_q       <= '0;
            cnt_q        <= '0;
            ev_valid_q   <= 1'b0;
            ev_data_q    <= '0;
            ev_changed_q <= '0;
            err_to_q     <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            int_cnt_q    <= int_cnt_d;
            to_cnt_q     <= to_cnt_d;
            sample_q     <= sample_d;
            stable_q     <= stable_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            ev_valid_q   <= ev_valid_d;
            ev_data_q    <= ev_data_d;
            ev_changed_q <= ev_changed_d;
            err_to_q     <= err_to_d;
            err_ovf_q    <= err_ovf_d;
        end
    end

    // Decoded straight from the state register so reset drops m_read at once.
    assign m_read       = (state_q == S_REQ);
    assign busy         = (state_q != S_IDLE);
    assign m_address    = 2'b00;
    assign stable_value = stable_q;
    assign ev_valid     = ev_valid_q;
    assign ev_data      = ev_data_q;
    assign ev_changed   = ev_changed_q;
    assign err_timeout  = err_to_q;
    assign err_overflow = err_ovf_q;

endmodule
